// File: rtl/xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xfer_pkg
// Purpose : Shared types for the two-memory transfer sequencer.
//           - state_e  : sequencer state encoding. IDLE is 0. The field is
//                        four bits wide because the nine states need it.
//           - strobe_t : bundle of memory datapath strobes.
//           - depth_a_legal() : checks that DEPTH_A is even and >= 2.
// Revision: 1.0 - initial release
// ============================================================================
package xfer_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_LOAD   = 4'd2,
    S_REWIND = 4'd3,
    S_RD0    = 4'd4,
    S_RD1    = 4'd5,
    S_WR     = 4'd6,
    S_INC    = 4'd7,
    S_DONE   = 4'd8
  } state_e;

  typedef struct packed {
    logic wea;
    logic inca;
    logic clra;
    logic web;
    logic incb;
    logic clrb;
  } strobe_t;

  localparam strobe_t STROBE_NONE = '0;

  function automatic bit depth_a_legal(input int depth);
    return (depth >= 2) && ((depth % 2) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xfer_step_counter.sv
`default_nettype none
// ============================================================================
// Module  : xfer_step_counter
// Purpose : Clear/enable up-counter with a terminal-count compare. The count
//           saturates at TERMINAL and never wraps.
// Ports   : clock   - rising-edge clock
//           Reset   - synchronous active-high reset (count -> 0)
//           clear   - synchronous clear (count -> 0)
//           enable  - advance the count by one
//           last    - count is TERMINAL-1, so the next enabled step reaches
//                     the terminal value
// Revision: 1.0 - initial release
// ============================================================================
module xfer_step_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 8
) (
  input  logic clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TERM_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == LAST_VAL);

endmodule
`default_nettype wire

// File: rtl/xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : xfer_sequencer
// Purpose : Start/done handshake sequencer for the two-memory transfer
//           datapath. Clears both address pointers, loads DEPTH_A words into
//           memory A under source flow control, rewinds A, then writes one
//           word into B per pair of A words read.
// Ports   : clock, Reset (sync, active-high)
//           start        - transfer request, sampled in IDLE only
//           load_valid   - source word present (LOAD only)
//           load_ready   - high in every LOAD cycle
//           WEA/IncA/ClrA, WEB/IncB/ClrB - memory datapath strobes
//           busy         - high in every state except IDLE
//           done         - one-cycle completion pulse
//           phase        - current state encoding (xfer_pkg::state_e)
//           abort/aborted - present only when XFER_SEQ_ABORT_EN is defined
// Config  : XFER_SEQ_ABORT_EN - adds the abort input and the registered
//           one-cycle aborted flag.
// Revision: 1.0 - initial release
// ============================================================================
module xfer_sequencer
  import xfer_pkg::*;
#(
  parameter int DEPTH_A = 8
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic               start,
  input  logic               load_valid,
`ifdef XFER_SEQ_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic               load_ready,
  output logic               WEA,
  output logic               IncA,
  output logic               ClrA,
  output logic               WEB,
  output logic               IncB,
  output logic               ClrB,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] phase
);

  localparam int WORD_W = $clog2(DEPTH_A + 1);
  localparam int PAIR_W = $clog2(DEPTH_A / 2 + 1);

  generate
    if (!depth_a_legal(DEPTH_A)) begin : g_depth_check
      $error("xfer_sequencer: DEPTH_A must be even and at least 2");
    end
  endgenerate

  state_e  state_q;
  state_e  state_d;
  strobe_t strobe;
  logic    abort_hit;
  logic    word_last;
  logic    pair_last;
  logic    cnt_clear;

`ifdef XFER_SEQ_ABORT_EN
  logic aborted_q;
  logic aborted_d;
  // DONE is already on its way out, so abort only acts on the working states.
  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);
  assign aborted_d = abort_hit;
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    strobe  = STROBE_NONE;
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        strobe.clra = 1'b1;
        strobe.clrb = 1'b1;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        if (load_valid) begin
          strobe.wea  = 1'b1;
          strobe.inca = 1'b1;
          // word_last means this accepted word is the DEPTH_A-th one.
          if (word_last) state_d = S_REWIND;
        end
      end
      S_REWIND: begin
        strobe.clra = 1'b1;
        state_d     = S_RD0;
      end
      S_RD0: begin
        strobe.inca = 1'b1;
        state_d     = S_RD1;
      end
      S_RD1: begin
        strobe.inca = 1'b1;
        state_d     = S_WR;
      end
      S_WR: begin
        strobe.web = 1'b1;
        state_d    = S_INC;
      end
      S_INC: begin
        strobe.incb = 1'b1;
        state_d     = pair_last ? S_DONE : S_RD0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // An abort suppresses every strobe in the cycle it is sampled.
    if (abort_hit) begin
      strobe  = STROBE_NONE;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
`ifdef XFER_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
`ifdef XFER_SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign cnt_clear = (state_q == S_START);

  // Accepted source words: one per WEA pulse.
  xfer_step_counter #(
    .WIDTH    (WORD_W),
    .TERMINAL (DEPTH_A)
  ) u_word_cnt (
    .clock  (clock),
    .Reset  (Reset),
    .clear  (cnt_clear),
    .enable (strobe.wea),
    .last   (word_last)
  );

  // Completed A pairs: one per IncB pulse.
  xfer_step_counter #(
    .WIDTH    (PAIR_W),
    .TERMINAL (DEPTH_A / 2)
  ) u_pair_cnt (
    .clock  (clock),
    .Reset  (Reset),
    .clear  (cnt_clear),
    .enable (strobe.incb),
    .last   (pair_last)
  );

  assign WEA        = strobe.wea;
  assign IncA       = strobe.inca;
  assign ClrA       = strobe.clra;
  assign WEB        = strobe.web;
  assign IncB       = strobe.incb;
  assign ClrB       = strobe.clrb;
  assign load_ready = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign phase      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_xfer_sequencer
// Purpose : Self-checking bench for xfer_sequencer. A queue-based transfer
//           model predicts every output each cycle; directed transfers also
//           pin cycle counts and strobe totals to hand-computed values.
//           A second instance with DEPTH_A=2 checks the minimum depth.
// Revision: 1.0 - initial release
// ============================================================================
module tb_xfer_sequencer;
  import xfer_pkg::*;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [STATE_W-1:0] phase;
    logic busy;
    logic done;
    logic load_ready;
    logic wea;
    logic inca;
    logic clra;
    logic web;
    logic incb;
    logic clrb;
  } vec_t;

  logic clock      = 1'b0;
  logic Reset      = 1'b1;
  logic start      = 1'b0;
  logic load_valid = 1'b0;
  logic abort      = 1'b0;
  logic start2     = 1'b0;
  logic lv2        = 1'b1;

  always #5 clock = ~clock;

  logic load_ready, WEA, IncA, ClrA, WEB, IncB, ClrB, busy, done, aborted;
  logic [STATE_W-1:0] phase;
  logic load_ready2, WEA2, IncA2, ClrA2, WEB2, IncB2, ClrB2, busy2, done2, aborted2;
  logic [STATE_W-1:0] phase2;

  xfer_sequencer #(.DEPTH_A(DEPTH)) u_dut (
    .clock(clock), .Reset(Reset), .start(start), .load_valid(load_valid),
`ifdef XFER_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .load_ready(load_ready), .WEA(WEA), .IncA(IncA), .ClrA(ClrA),
    .WEB(WEB), .IncB(IncB), .ClrB(ClrB), .busy(busy), .done(done), .phase(phase)
  );

  xfer_sequencer #(.DEPTH_A(2)) u_dut2 (
    .clock(clock), .Reset(Reset), .start(start2), .load_valid(lv2),
`ifdef XFER_SEQ_ABORT_EN
    .abort(1'b0), .aborted(aborted2),
`endif
    .load_ready(load_ready2), .WEA(WEA2), .IncA(IncA2), .ClrA(ClrA2),
    .WEB(WEB2), .IncB(IncB2), .ClrB(ClrB2), .busy(busy2), .done(done2), .phase(phase2)
  );

`ifndef XFER_SEQ_ABORT_EN
  assign aborted  = 1'b0;
  assign aborted2 = 1'b0;
`endif

  // ---------------------------------------------------------------- model
  vec_t mq[$];
  bit   m_load    = 0;
  int   m_words   = 0;
  bit   m_aborted = 0;
  bit   m_valid   = 0;

  function automatic vec_t mk(state_e s, bit wea, bit inca, bit clra,
                              bit web, bit incb, bit clrb);
    vec_t v;
    v.phase      = s;
    v.busy       = (s != S_IDLE);
    v.done       = (s == S_DONE);
    v.load_ready = (s == S_LOAD);
    v.wea = wea; v.inca = inca; v.clra = clra;
    v.web = web; v.incb = incb; v.clrb = clrb;
    return v;
  endfunction

  function automatic bit m_active();
    if (mq.size() > 0) return mq[0].phase != S_DONE;
    return m_load;
  endfunction

  function automatic vec_t exp_now();
    vec_t v;
    if (mq.size() > 0)  v = mq[0];
    else if (m_load)    v = mk(S_LOAD, load_valid, load_valid, 0, 0, 0, 0);
    else                v = mk(S_IDLE, 0, 0, 0, 0, 0, 0);
    if (abort && m_active()) begin
      v.wea = 0; v.inca = 0; v.clra = 0; v.web = 0; v.incb = 0; v.clrb = 0;
    end
    return v;
  endfunction

  always @(posedge clock) begin
    vec_t v;
    if (Reset) begin
      mq.delete();
      m_load    = 0;
      m_aborted = 0;
      m_valid   = 1;
    end else begin
      m_aborted = 0;
      if (abort && m_active()) begin
        mq.delete();
        m_load    = 0;
        m_aborted = 1;
      end else if (mq.size() > 0) begin
        v = mq.pop_front();
        if (v.phase == S_START) begin
          m_load  = 1;
          m_words = 0;
        end
      end else if (m_load) begin
        if (load_valid) m_words++;
        if (m_words == DEPTH) begin
          m_load = 0;
          mq.push_back(mk(S_REWIND, 0, 0, 1, 0, 0, 0));
          for (int p = 0; p < DEPTH / 2; p++) begin
            mq.push_back(mk(S_RD0, 0, 1, 0, 0, 0, 0));
            mq.push_back(mk(S_RD1, 0, 1, 0, 0, 0, 0));
            mq.push_back(mk(S_WR,  0, 0, 0, 1, 0, 0));
            mq.push_back(mk(S_INC, 0, 0, 0, 0, 1, 0));
          end
          mq.push_back(mk(S_DONE, 0, 0, 0, 0, 0, 0));
        end
      end else if (start) begin
        mq.push_back(mk(S_START, 0, 0, 1, 0, 0, 1));
      end
    end
  end

  // ------------------------------------------------------------- checking
  int checks   = 0;
  int failures = 0;

  // Literal expectations for the current directed transfer (0 = none).
  int exp_done  = 0;
  int exp_clra2 = 0;
  int exp_gap   = 0;
  int timeout_cnt  = 0;
  int timeout_seen = 0;

  int cyc = 0, last_done_cyc = 0;
  int t = 0, n_wea = 0, n_web = 0, n_incb = 0, n_clra = 0, clra1 = 0, clra2 = 0;
  int t2 = 0, w2 = 0, ia2 = 0, ca2 = 0, cb2 = 0, b2 = 0, ib2 = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endfunction

  always @(negedge clock) begin
    vec_t act;
    cyc++;
    if (timeout_cnt != timeout_seen) begin
      chk("wait_bound_expired", 32'(timeout_cnt), 32'(timeout_seen));
      timeout_seen = timeout_cnt;
    end
    if (m_valid) begin
      act = {phase, busy, done, load_ready, WEA, IncA, ClrA, WEB, IncB, ClrB};
      chk("outputs", 32'(act), 32'(exp_now()));
      chk("aborted", 32'(aborted), 32'(m_aborted));

      // Per-transfer statistics, cycle 1 = START.
      if (phase == S_START) begin
        if (exp_gap != 0) chk("start_after_done_gap", 32'(cyc - last_done_cyc), 32'(exp_gap));
        t = 1; n_wea = 0; n_web = 0; n_incb = 0; n_clra = 0; clra1 = 0; clra2 = 0;
      end else if (t > 0) begin
        t++;
      end
      if (t > 0) begin
        n_wea  += int'(WEA);
        n_web  += int'(WEB);
        n_incb += int'(IncB);
        if (ClrA) begin
          if (n_clra == 0) clra1 = t;
          else if (n_clra == 1) clra2 = t;
          n_clra++;
        end
        if (done) begin
          if (exp_done != 0) begin
            chk("done_cycle", 32'(t), 32'(exp_done));
            chk("wea_count",  32'(n_wea), 32'd8);
            chk("web_count",  32'(n_web), 32'd4);
            chk("incb_count", 32'(n_incb), 32'd4);
            chk("clra_first", 32'(clra1), 32'd1);
            chk("clra_second", 32'(clra2), 32'(exp_clra2));
          end
          last_done_cyc = cyc;
          t = 0;
        end
      end

      // DEPTH_A=2 instance.
      chk("dut2_status", {30'd0, busy2, load_ready2},
          {30'd0, phase2 != S_IDLE, phase2 == S_LOAD});
      if (phase2 == S_START) begin
        t2 = 1; w2 = 0; ia2 = 0; ca2 = 0; cb2 = 0; b2 = 0; ib2 = 0;
      end else if (t2 > 0) begin
        t2++;
      end
      if (t2 > 0) begin
        w2 += int'(WEA2); ia2 += int'(IncA2); ca2 += int'(ClrA2);
        cb2 += int'(ClrB2); b2 += int'(WEB2); ib2 += int'(IncB2);
        if (done2) begin
          chk("d2_done_cycle", 32'(t2), 32'd9);
          chk("d2_wea", 32'(w2), 32'd2);
          chk("d2_inca", 32'(ia2), 32'd4);
          chk("d2_clra", 32'(ca2), 32'd2);
          chk("d2_clrb", 32'(cb2), 32'd1);
          chk("d2_web", 32'(b2), 32'd1);
          chk("d2_incb", 32'(ib2), 32'd1);
          t2 = 0;
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clock);
      if (done) break;
    end
    if (k == bound) timeout_cnt++;
  endtask

  task automatic wait_phase(input state_e s, input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clock);
      if (phase == s) break;
    end
    if (k == bound) timeout_cnt++;
  endtask

  initial begin
    // Reset, then idle.
    Reset = 1; repeat (3) tick();
    Reset = 0; repeat (5) tick();

    // Full transfer, load_valid held high.
    exp_done = 27; exp_clra2 = 10;
    start = 1; load_valid = 1; tick();
    start = 0;
    wait_done(100);
    tick(); exp_done = 0;
    repeat (3) tick();

    // load_valid low in cycles 4..6.
    exp_done = 30; exp_clra2 = 13;
    start = 1; tick();          // cycle 1
    start = 0; tick(); tick();  // cycles 2, 3
    tick(); load_valid = 0;     // cycle 4
    tick(); tick();             // cycles 5, 6
    tick(); load_valid = 1;     // cycle 7
    wait_done(100);
    tick(); exp_done = 0;
    repeat (3) tick();

    // start held through two transfers.
    exp_done = 27; exp_clra2 = 10;
    start = 1;
    wait_done(100);
    tick(); exp_gap = 2;
    wait_done(100);
    start = 0;
    tick(); exp_done = 0; exp_gap = 0;
    repeat (3) tick();

    // Reset in WR, then a normal transfer.
    start = 1; tick(); start = 0;
    wait_phase(S_WR, 100);
    Reset = 1; tick(); Reset = 0;
    repeat (3) tick();
    exp_done = 27; exp_clra2 = 10;
    start = 1; tick(); start = 0;
    wait_done(100);
    tick(); exp_done = 0;
    repeat (3) tick();

`ifdef XFER_SEQ_ABORT_EN
    // Abort in RD1, then abort in IDLE.
    start = 1; tick(); start = 0;
    wait_phase(S_RD0, 100);
    tick(); abort = 1;          // RD1 cycle
    tick(); abort = 0;
    repeat (4) tick();
    abort = 1; tick(); abort = 0;
    repeat (3) tick();
`endif

    // Minimum depth instance.
    start2 = 1; tick(); start2 = 0;
    repeat (15) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      Reset      = ($urandom_range(0, 399) == 0);
      start      = ($urandom_range(0, 5) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
`ifdef XFER_SEQ_ABORT_EN
      abort      = ($urandom_range(0, 79) == 0);
`endif
    end
    tick();
    Reset = 0; start = 0; load_valid = 0; abort = 0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
